icela_rx: RTL and testbench

- Receive-side counterpart of the icestick logic analyzer's UART Tx path.
- Deserialises the 115200 8N1 byte stream and re-frames the 5-byte '\nCCCP' messages: LF, 24-bit counter (MSB first), then an overflow bit followed by 7 pin bits.
- Presents each decoded record as a single-cycle strobe.
- Used for loopback self-test on a second board and as the front end of an on-FPGA capture checker.

---
 rtl/icela_rx.sv | 193 +++++++++++++++++++
 tb/tb_icela_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/icela_rx.sv
// icela_rx: UART receiver and message re-framer for the icestick logic
// analyzer stream. Recovers 8N1 bytes with a 16x fractional-divider
// oversample tick, then parses '\n' + 24-bit counter + {oflow, pins}
// records into single-cycle strobes.
module icela_rx #(
  parameter int unsigned Width = 13,
  parameter int unsigned Incr  = 1258,
  parameter int unsigned NPIN  = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            serrx,
  output logic [7:0]      byte_data,
  output logic            byte_valid,
  output logic            frame_err,
  output logic            sync_drop,
  output logic [23:0]     timebase,
  output logic            oflow,
  output logic [NPIN-1:0] pin,
  output logic            valid
);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  typedef enum logic [2:0] {
    P_HUNT,
    P_C0,
    P_C1,
    P_C2,
    P_P
  } p_state_t;

  logic             sync1;
  logic             rxs;
  logic [Width-1:0] acc;
  logic             tick;
  rx_state_t        rx_state;
  logic [3:0]       phase;
  logic [2:0]       bitcnt;
  logic [7:0]       shreg;
  p_state_t         p_state;
  logic [23:0]      cnt;

  // Two-stage synchroniser; resets to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= serrx;
      rxs   <= sync1;
    end
  end

  // Fractional divider: carry-out of the accumulator is the 16x tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {tick, acc} <= '0;
    end else begin
      {tick, acc} <= {1'b0, acc} + (Width + 1)'(Incr);
    end
  end

  // Byte receiver: start-bit qualification at mid bit, LSB-first data,
  // stop-bit check, and break handling via RX_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      phase      <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rxs) begin
            phase    <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (phase == 4'd7) begin
              if (rxs) begin
                rx_state <= RX_IDLE;
              end else begin
                phase    <= '0;
                bitcnt   <= '0;
                rx_state <= RX_DATA;
              end
            end else begin
              phase <= phase + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            phase <= phase + 4'd1;
            if (phase == 4'd15) begin
              shreg  <= {rxs, shreg[7:1]};
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                rx_state <= RX_STOP;
              end
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            phase <= phase + 4'd1;
            if (phase == 4'd15) begin
              if (rxs) begin
                byte_data  <= shreg;
                byte_valid <= 1'b1;
                rx_state   <= RX_IDLE;
              end else begin
                frame_err <= 1'b1;
                rx_state  <= RX_WAIT;
              end
            end
          end
        end
        RX_WAIT: begin
          if (rxs) begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Message parser: hunt for LF, collect counter bytes MSB first, then
  // publish the record; a framing error aborts a partial message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state   <= P_HUNT;
      cnt       <= '0;
      sync_drop <= 1'b0;
      timebase  <= '0;
      oflow     <= 1'b0;
      pin       <= '0;
      valid     <= 1'b0;
    end else begin
      sync_drop <= 1'b0;
      valid     <= 1'b0;
      if (frame_err && (p_state != P_HUNT)) begin
        p_state <= P_HUNT;
      end else if (byte_valid) begin
        case (p_state)
          P_HUNT: begin
            if (byte_data == 8'h0A) begin
              p_state <= P_C0;
            end else begin
              sync_drop <= 1'b1;
            end
          end
          P_C0: begin
            cnt[23:16] <= byte_data;
            p_state    <= P_C1;
          end
          P_C1: begin
            cnt[15:8] <= byte_data;
            p_state   <= P_C2;
          end
          P_C2: begin
            cnt[7:0] <= byte_data;
            p_state  <= P_P;
          end
          P_P: begin
            timebase <= cnt;
            oflow    <= byte_data[7];
            pin      <= byte_data[NPIN-1:0];
            valid    <= 1'b1;
            p_state  <= P_HUNT;
          end
          default: p_state <= P_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icela_rx.sv
// tb_icela_rx: directed message vectors sent as 8N1 serial frames, plus
// hand-written glitch, break and mid-message reset sequences.
`timescale 1ns/1ps
module tb_icela_rx;

  localparam int BIT = 104;  // clk cycles per bit at 12 MHz / 115200

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        serrx = 1'b1;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        frame_err;
  logic        sync_drop;
  logic [23:0] timebase;
  logic        oflow;
  logic [6:0]  pin;
  logic        valid;

  always #5 clk = ~clk;

  icela_rx #(.Width(13), .Incr(1258), .NPIN(7)) dut (
    .clk(clk), .rst_n(rst_n), .serrx(serrx),
    .byte_data(byte_data), .byte_valid(byte_valid), .frame_err(frame_err),
    .sync_drop(sync_drop), .timebase(timebase), .oflow(oflow), .pin(pin),
    .valid(valid)
  );

  int total = 0;
  int bad = 0;

  // strobe monitor
  int n_bv, n_err, n_drop, n_valid, n_excl;
  logic [23:0] l_tb;
  logic        l_of;
  logic [6:0]  l_pin;
  logic [7:0]  rxq[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid) begin n_bv++; rxq.push_back(byte_data); end
      if (frame_err) n_err++;
      if (sync_drop) n_drop++;
      if (valid) begin n_valid++; l_tb = timebase; l_of = oflow; l_pin = pin; end
      if ((int'(byte_valid) + int'(frame_err) + int'(sync_drop)) > 1 || (valid && byte_valid))
        n_excl++;
    end
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] actual=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_bv = 0; n_err = 0; n_drop = 0; n_valid = 0; n_excl = 0;
    l_tb = '0; l_of = 1'b0; l_pin = '0;
    rxq.delete();
  endtask

  task automatic idle(input int n);
    serrx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input int stoplen);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      serrx = fr[k];
      repeat ((k == 9) ? stoplen : BIT) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outputs_zero(input int idx);
    chk("rst_byte_data", idx, 32'(byte_data), 0);
    chk("rst_byte_valid", idx, 32'(byte_valid), 0);
    chk("rst_frame_err", idx, 32'(frame_err), 0);
    chk("rst_sync_drop", idx, 32'(sync_drop), 0);
    chk("rst_timebase", idx, 32'(timebase), 0);
    chk("rst_oflow", idx, 32'(oflow), 0);
    chk("rst_pin", idx, 32'(pin), 0);
    chk("rst_valid", idx, 32'(valid), 0);
  endtask

  typedef struct {
    int unsigned nb;       // bytes sent
    logic [63:0] msg;      // first byte in [63:56]
    logic [7:0]  badstop;  // bit i: byte i sent with a low stop bit
    int          gap;      // idle clks between bytes
    int          stoplen;  // stop bit length in clks
    int          e_bv;
    int          e_drop;
    int          e_err;
    int          e_valid;
    logic [23:0] e_tb;
    logic        e_of;
    logic [6:0]  e_pin;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{nb:5, msg:64'h0A12345685000000, badstop:8'h00, gap:0,  stoplen:BIT,
                e_bv:5, e_drop:0, e_err:0, e_valid:1, e_tb:24'h123456, e_of:1'b1, e_pin:7'h05};
    vecs[1] = '{nb:7, msg:64'h41420A000A007F00, badstop:8'h00, gap:50, stoplen:BIT,
                e_bv:7, e_drop:2, e_err:0, e_valid:1, e_tb:24'h000A00, e_of:1'b0, e_pin:7'h7F};
    vecs[2] = '{nb:8, msg:64'h0A01550AFFFFFF00, badstop:8'h04, gap:0,  stoplen:BIT,
                e_bv:7, e_drop:0, e_err:1, e_valid:1, e_tb:24'hFFFFFF, e_of:1'b0, e_pin:7'h00};
    vecs[3] = '{nb:5, msg:64'h0A0A0A0A0A000000, badstop:8'h00, gap:0,  stoplen:BIT,
                e_bv:5, e_drop:0, e_err:0, e_valid:1, e_tb:24'h0A0A0A, e_of:1'b0, e_pin:7'h0A};
    // shortened stop bits: next start edge arrives early
    vecs[4] = '{nb:5, msg:64'h0A800000FF000000, badstop:8'h00, gap:0,  stoplen:78,
                e_bv:5, e_drop:0, e_err:0, e_valid:1, e_tb:24'h800000, e_of:1'b1, e_pin:7'h7F};

    clear_mon();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_outputs_zero(0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2 * BIT);

    for (int unsigned v = 0; v < 5; v++) begin
      int unsigned j;
      logic [7:0] b;
      clear_mon();
      for (int unsigned i = 0; i < vecs[v].nb; i++) begin
        b = vecs[v].msg[63 - 8*i -: 8];
        send_byte(b, !vecs[v].badstop[i], vecs[v].stoplen);
        if (vecs[v].badstop[i]) idle(2 * BIT);
        else if (vecs[v].gap > 0) idle(vecs[v].gap);
      end
      idle(3 * BIT);
      chk("n_byte_valid", int'(v), 32'(n_bv), 32'(vecs[v].e_bv));
      chk("n_sync_drop", int'(v), 32'(n_drop), 32'(vecs[v].e_drop));
      chk("n_frame_err", int'(v), 32'(n_err), 32'(vecs[v].e_err));
      chk("n_valid", int'(v), 32'(n_valid), 32'(vecs[v].e_valid));
      chk("timebase", int'(v), 32'(l_tb), 32'(vecs[v].e_tb));
      chk("oflow", int'(v), 32'(l_of), 32'(vecs[v].e_of));
      chk("pin", int'(v), 32'(l_pin), 32'(vecs[v].e_pin));
      chk("held_timebase", int'(v), 32'(timebase), 32'(vecs[v].e_tb));
      chk("exclusive", int'(v), 32'(n_excl), 0);
      j = 0;
      for (int unsigned i = 0; i < vecs[v].nb; i++) begin
        if (!vecs[v].badstop[i]) begin
          b = vecs[v].msg[63 - 8*i -: 8];
          if (j < rxq.size()) chk("byte", int'(v * 10 + j), 32'(rxq[j]), 32'(b));
          j++;
        end
      end
    end

    // short low glitch on the idle line: rejected at the mid-start sample
    clear_mon();
    serrx = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    idle(2 * BIT);
    chk("glitch_bv", 0, 32'(n_bv), 0);
    chk("glitch_err", 0, 32'(n_err), 0);
    chk("glitch_drop", 0, 32'(n_drop), 0);
    chk("glitch_valid", 0, 32'(n_valid), 0);
    chk("glitch_rx_idle", 0, 32'(dut.rx_state), 0);

    // break: 30 bit times low gives a single framing error
    clear_mon();
    serrx = 1'b0;
    repeat (30 * BIT) @(posedge clk);
    #1;
    idle(2 * BIT);
    chk("break_err", 0, 32'(n_err), 1);
    chk("break_bv", 0, 32'(n_bv), 0);
    send_byte(8'h0A, 1'b1, BIT);
    send_byte(8'h00, 1'b1, BIT);
    send_byte(8'h00, 1'b1, BIT);
    send_byte(8'h01, 1'b1, BIT);
    send_byte(8'h01, 1'b1, BIT);
    idle(3 * BIT);
    chk("break_err_total", 0, 32'(n_err), 1);
    chk("break_valid", 0, 32'(n_valid), 1);
    chk("break_timebase", 0, 32'(l_tb), 1);
    chk("break_pin", 0, 32'(l_pin), 1);
    chk("break_oflow", 0, 32'(l_of), 0);
    chk("break_drop", 0, 32'(n_drop), 0);

    // reset in the middle of byte 3 of a message
    clear_mon();
    send_byte(8'h0A, 1'b1, BIT);
    send_byte(8'h11, 1'b1, BIT);
    send_byte(8'h22, 1'b1, BIT);
    serrx = 1'b0;                      // start bit of 0x33
    repeat (BIT) @(posedge clk); #1;
    serrx = 1'b1;                      // bits 0,1
    repeat (2 * BIT) @(posedge clk); #1;
    serrx = 1'b0;                      // bits 2,3
    repeat (2 * BIT) @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero(1);
    serrx = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_outputs_zero(2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2 * BIT);
    chk("rst_no_valid", 0, 32'(n_valid), 0);
    send_byte(8'h0A, 1'b1, BIT);
    send_byte(8'hAB, 1'b1, BIT);
    send_byte(8'hCD, 1'b1, BIT);
    send_byte(8'hEF, 1'b1, BIT);
    send_byte(8'h03, 1'b1, BIT);
    idle(3 * BIT);
    chk("rst_bv", 0, 32'(n_bv), 8);
    chk("rst_valid_cnt", 0, 32'(n_valid), 1);
    chk("rst_timebase_after", 0, 32'(l_tb), 32'h00ABCDEF);
    chk("rst_oflow_after", 0, 32'(l_of), 0);
    chk("rst_pin_after", 0, 32'(l_pin), 3);
    chk("rst_err", 0, 32'(n_err), 0);
    chk("rst_drop", 0, 32'(n_drop), 0);
    chk("rst_exclusive", 0, 32'(n_excl), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
